// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, coin values and product indices for the vending sequencer
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBIT,
    S_DISPENSE,
    S_CHANGE,
    S_GAP,
    S_DONE
  } vend_state_t;

  localparam int COIN_QUARTER = 25;
  localparam int COIN_DIME    = 10;
  localparam int COIN_NICKEL  = 5;

  localparam logic [2:0] EJ_QUARTER = 3'b100;
  localparam logic [2:0] EJ_DIME    = 3'b010;
  localparam logic [2:0] EJ_NICKEL  = 3'b001;

  localparam logic [1:0] PROD_GUM     = 2'd0;
  localparam logic [1:0] PROD_CANDY   = 2'd1;
  localparam logic [1:0] PROD_CHIPS   = 2'd2;
  localparam logic [1:0] PROD_COOKIES = 2'd3;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = PROD_GUM;
    if (oh[1]) idx = PROD_CANDY;
    if (oh[2]) idx = PROD_CHIPS;
    if (oh[3]) idx = PROD_COOKIES;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter; search starts one past the last grant
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending sequencer: grant, debit, dispense, greedy change, credit clear
// Optional: VEND_DEBIT_TIMEOUT_EN aborts a debit that is not acknowledged within 16 cycles.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int DISP_CYCLES = 4,
  parameter int COIN_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*CREDIT_W-1:0] price,
  input  logic [CREDIT_W-1:0]   credit,
  input  logic                  cancel,
  output logic                  sub_req,
  output logic [CREDIT_W-1:0]   sub_amt,
  input  logic                  sub_ack,
  output logic [3:0]            disp,
  output logic [2:0]            eject,
  output logic                  credit_clr,
  output logic                  denied,
  output logic                  busy
);

  localparam logic [CREDIT_W-1:0] AMT_Q = CREDIT_W'(COIN_QUARTER);
  localparam logic [CREDIT_W-1:0] AMT_D = CREDIT_W'(COIN_DIME);
  localparam logic [CREDIT_W-1:0] AMT_N = CREDIT_W'(COIN_NICKEL);
  localparam logic [15:0] DISP_LAST = 16'(DISP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(COIN_GAP - 1);
`ifdef VEND_DEBIT_TIMEOUT_EN
  localparam logic [15:0] DEBIT_LAST = 16'd15;
`endif

  vend_state_t         state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          gidx_q, gidx_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                denied_q, denied_d;

  logic [3:0]          gnt;
  logic [1:0]          gidx;
  logic [CREDIT_W-1:0] sel_price;

  // ptr_q is the next index to search from, so the arbiter sees the one before it
  rr_arbiter4 u_arb (
    .req  (req),
    .last (ptr_q - 2'd1),
    .gnt  (gnt)
  );

  assign gidx      = onehot_to_idx(gnt);
  assign sel_price = price[int'(gidx)*CREDIT_W +: CREDIT_W];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    price_d    = price_q;
    credit_d   = credit_q;
    change_d   = change_q;
    cnt_d      = cnt_q;
    denied_d   = 1'b0;
    sub_req    = 1'b0;
    sub_amt    = '0;
    disp       = 4'b0000;
    eject      = 3'b000;
    credit_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          change_d = credit;
          state_d  = S_CHANGE;
        end else if (|req) begin
          ptr_d = gidx + 2'd1;
          if (credit >= sel_price) begin
            gidx_d   = gidx;
            price_d  = sel_price;
            credit_d = credit;
            cnt_d    = '0;
            state_d  = S_DEBIT;
          end else begin
            denied_d = 1'b1;
          end
        end
      end
      S_DEBIT: begin
        sub_req = 1'b1;
        sub_amt = price_q;
        if (sub_ack) begin
          change_d = credit_q - price_q;
          cnt_d    = '0;
          state_d  = S_DISPENSE;
`ifdef VEND_DEBIT_TIMEOUT_EN
        end else if (cnt_q == DEBIT_LAST) begin
          denied_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`else
        end
`endif
      end
      S_DISPENSE: begin
        disp[gidx_q] = 1'b1;
        if (cnt_q == DISP_LAST) begin
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CHANGE: begin
        cnt_d   = '0;
        state_d = S_GAP;
        if (change_q >= AMT_Q) begin
          eject    = EJ_QUARTER;
          change_d = change_q - AMT_Q;
        end else if (change_q >= AMT_D) begin
          eject    = EJ_DIME;
          change_d = change_q - AMT_D;
        end else if (change_q >= AMT_N) begin
          eject    = EJ_NICKEL;
          change_d = change_q - AMT_N;
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_CHANGE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        credit_clr = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign denied = denied_q;
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= PROD_GUM;
      gidx_q   <= PROD_GUM;
      price_q  <= '0;
      credit_q <= '0;
      change_q <= '0;
      cnt_q    <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      price_q  <= price_d;
      credit_q <= credit_d;
      change_q <= change_d;
      cnt_q    <= cnt_d;
      denied_q <= denied_d;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed bench with a transaction-level model of vend_sequencer
module tb_vend_sequencer;

  localparam int CW = 8;
  localparam int DC = 4;
  localparam int CG = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req;
  logic [4*CW-1:0] price;
  logic [CW-1:0] credit;
  logic          cancel;
  logic          sub_req;
  logic [CW-1:0] sub_amt;
  logic          sub_ack;
  logic [3:0]    disp;
  logic [2:0]    eject;
  logic          credit_clr;
  logic          denied;
  logic          busy;

  int prices[4];
  assign price = {8'(prices[3]), 8'(prices[2]), 8'(prices[1]), 8'(prices[0])};

  vend_sequencer #(.CREDIT_W(CW), .DISP_CYCLES(DC), .COIN_GAP(CG)) dut (
    .clk(clk), .rst(rst), .req(req), .price(price), .credit(credit), .cancel(cancel),
    .sub_req(sub_req), .sub_amt(sub_amt), .sub_ack(sub_ack), .disp(disp), .eject(eject),
    .credit_clr(credit_clr), .denied(denied), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output word: {sub_req, sub_amt, disp, eject, credit_clr, denied, busy}
  typedef logic [18:0] word_t;
  localparam word_t IDLE_W = 19'h0;
  localparam word_t BUSY_W = 19'h1;

  word_t act;
  assign act = {sub_req, sub_amt, disp, eject, credit_clr, denied, busy};

  word_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int m_next;

  int ej_log[$];
  int disp_log[$];
  int clr_cnt, den_cnt, sr_cnt, amt_seen;
  logic [3:0] prev_disp = 4'b0;

  function automatic word_t mk(logic sr, logic [7:0] amt, logic [3:0] d, logic [2:0] e,
                               logic clr, logic den, logic bsy);
    return {sr, amt, d, e, clr, den, bsy};
  endfunction

  always @(negedge clk) begin
    word_t e;
    word_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act;
      if (!e[18]) a[17:10] = 8'h00;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t actual=%05h expected=%05h", $time, a, e);
      end
    end
  end

  always @(negedge clk) begin
    if (eject != 3'b0) ej_log.push_back(int'(eject));
    if (disp != 4'b0 && prev_disp == 4'b0) disp_log.push_back(int'(disp));
    prev_disp = disp;
    if (credit_clr) clr_cnt++;
    if (denied) den_cnt++;
    if (sub_req) begin
      sr_cnt++;
      amt_seen = int'(sub_amt);
    end
  end

  task automatic clear_logs();
    ej_log.delete();
    disp_log.delete();
    clr_cnt = 0; den_cnt = 0; sr_cnt = 0; amt_seen = 0;
  endtask

  function automatic int enc_ej();
    int v = 0;
    foreach (ej_log[i]) v = v * 16 + ej_log[i];
    return v;
  endfunction

  function automatic int enc_disp();
    int v = 0;
    foreach (disp_log[i]) v = v * 16 + disp_log[i];
    return v;
  endfunction

  task automatic check(string name, int actual, int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int pick(logic [3:0] r);
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (m_next + off) % 4;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // Greedy change from the rules: coin, gap cycles, then a final empty look and the clear.
  function automatic void push_change(int ch);
    while (ch >= 5) begin
      logic [2:0] e;
      if (ch >= 25) begin e = 3'b100; ch -= 25; end
      else if (ch >= 10) begin e = 3'b010; ch -= 10; end
      else begin e = 3'b001; ch -= 5; end
      exp_q.push_back(mk(1'b0, 8'h0, 4'h0, e, 1'b0, 1'b0, 1'b1));
      for (int k = 0; k < CG; k++) exp_q.push_back(BUSY_W);
    end
    exp_q.push_back(BUSY_W);
    exp_q.push_back(mk(1'b0, 8'h0, 4'h0, 3'b0, 1'b1, 1'b0, 1'b1));
  endfunction

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < 300);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout remaining=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic purchase(logic [3:0] r, int cr, int ack_delay, bit hold, output int pushed);
    int g;
    int p;
    g = pick(r);
    m_next = (g + 1) % 4;
    p = prices[g];
    exp_q.push_back(IDLE_W);
    for (int k = 0; k <= ack_delay; k++) exp_q.push_back(mk(1'b1, 8'(p), 4'h0, 3'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < DC; k++) exp_q.push_back(mk(1'b0, 8'h0, 4'(1 << g), 3'b0, 1'b0, 1'b0, 1'b1));
    push_change(cr - p);
    pushed = exp_q.size();
    req = r;
    credit = 8'(cr);
    @(posedge clk); #1;
    if (!hold) req = 4'b0;
    repeat (ack_delay) begin @(posedge clk); #1; end
    sub_ack = 1'b1;
    @(posedge clk); #1;
    sub_ack = 1'b0;
    drain();
  endtask

  task automatic deny(logic [3:0] r, int cr);
    int g;
    g = pick(r);
    m_next = (g + 1) % 4;
    exp_q.push_back(IDLE_W);
    exp_q.push_back(mk(1'b0, 8'h0, 4'h0, 3'b0, 1'b0, 1'b1, 1'b0));
    req = r;
    credit = 8'(cr);
    @(posedge clk); #1;
    req = 4'b0;
    drain();
  endtask

  task automatic cancel_tx(logic [3:0] r, int cr);
    exp_q.push_back(IDLE_W);
    push_change(cr);
    cancel = 1'b1;
    req = r;
    credit = 8'(cr);
    @(posedge clk); #1;
    cancel = 1'b0;
    req = 4'b0;
    drain();
  endtask

`ifdef VEND_DEBIT_TIMEOUT_EN
  task automatic timeout_tx(logic [3:0] r, int cr);
    int g;
    g = pick(r);
    m_next = (g + 1) % 4;
    exp_q.push_back(IDLE_W);
    for (int k = 0; k < 16; k++) exp_q.push_back(mk(1'b1, 8'(prices[g]), 4'h0, 3'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 8'h0, 4'h0, 3'b0, 1'b0, 1'b1, 1'b0));
    req = r;
    credit = 8'(cr);
    @(posedge clk); #1;
    req = 4'b0;
    drain();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req = 4'b0; credit = '0; cancel = 1'b0; sub_ack = 1'b0;
    prices = '{50, 65, 30, 40};
    m_next = 0;
    clear_logs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'(act), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // candy at 65 from 100: debit 65, four-cycle strobe, quarter then dime
    clear_logs();
    purchase(4'b0010, 100, 2, 1'b0, n);
    check("model_len_038", n, 16);
    check("eject_seq_038", enc_ej(), 'h42);
    check("disp_038", enc_disp(), 'h2);
    check("clr_038", clr_cnt, 1);
    check("sub_amt_038", amt_seen, 65);

    // gum at 50 with only 40
    clear_logs();
    deny(4'b0001, 40);
    check("denied_cnt_039", den_cnt, 1);
    check("sub_req_039", sr_cnt, 0);

    // cancel wins over a chips request
    clear_logs();
    cancel_tx(4'b0100, 45);
    check("eject_seq_041", enc_ej(), 'h422);
    check("disp_041", enc_disp(), 0);
    check("clr_041", clr_cnt, 1);

    // reset while waiting out the gap after the first coin
    clear_logs();
    exp_q.push_back(IDLE_W);
    exp_q.push_back(mk(1'b0, 8'h0, 4'h0, 3'b100, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(BUSY_W);
    cancel = 1'b1;
    credit = 8'd30;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_gap_outputs", int'(act), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_next = 0;
    clear_logs();
    repeat (4) @(negedge clk);
    check("quiet_after_rst", enc_ej() + clr_cnt + den_cnt + sr_cnt, 0);
    @(posedge clk); #1;

    // all four requested and affordable: fair rotation from index 0
    prices = '{30, 30, 30, 30};
    clear_logs();
    for (int t = 0; t < 4; t++) purchase(4'b1111, 30, 0, 1'b1, n);
    req = 4'b0;
    check("rr_order_040", enc_disp(), 'h1248);

    // slow acknowledge, 70 cents change
    clear_logs();
    purchase(4'b1000, 100, 20, 1'b0, n);
    check("eject_seq_slow", enc_ej(), 'h4422);
    check("disp_slow", enc_disp(), 'h8);

`ifdef VEND_DEBIT_TIMEOUT_EN
    clear_logs();
    timeout_tx(4'b0100, 100);
    check("timeout_denied", den_cnt, 1);
    check("timeout_disp", enc_disp(), 0);
    check("timeout_clr", clr_cnt, 0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
